pkt_credit_arbiter: RTL and testbench
=====================================

PKT_CREDIT_ARBITER -- requirements
Module: pkt_credit_arbiter

Interface
REQ-001 SHALL have parameter CREDITS, default 4, meaning downstream buffer depth in flits (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port req, input, 5, per-port flit-valid; bit0=N, bit1=E, bit2=W, bit3=S, bit4=L.
REQ-005 SHALL have port tail, input, 5, per-port tail-flit flag, meaningful only with the matching req bit.
REQ-006 SHALL have port credit_in, input, 1, one credit returned by downstream this cycle.
REQ-007 SHALL have port grant, output, 5, one-hot flit-accept to the owning requester, combinational.
REQ-008 SHALL have port xbar_sel, output, 5, one-hot crossbar select of the current owner, registered.
REQ-009 SHALL have port valid_out, output, 1, flit forwarded downstream this cycle (equal to |grant).
REQ-010 SHALL have port credit_cnt, output, 3, current available downstream credits.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and LOCKED, plus a 3-bit round-robin pointer ptr (0..4) and a registered owner index.
REQ-012 In IDLE with req!=0, SHALL select the first set req bit scanning from ptr upward, wrapping 4->0, register it as owner, and enter LOCKED next cycle.
REQ-013 In IDLE, grant, valid_out and xbar_sel SHALL be 0; arbitration latency is exactly one cycle from req to LOCKED.
REQ-014 In LOCKED, xbar_sel SHALL be one-hot of owner; grant[owner] = req[owner] AND (credit_cnt != 0); all other grant bits 0.
REQ-015 In LOCKED, when grant[owner]=1 and tail[owner]=1, the FSM SHALL return to IDLE and set ptr = (owner+1) mod 5 on the same edge.
REQ-016 In LOCKED, deasserted req[owner] without a tail SHALL keep the lock (packet in progress); other requesters SHALL be ignored until the tail.
REQ-017 A single-flit packet (req and tail together) SHALL occupy exactly one LOCKED cycle when credits are available.
REQ-018 credit_cnt SHALL decrement by 1 on valid_out, increment by 1 on credit_in, and hold when both occur in the same cycle.
REQ-019 credit_cnt SHALL never exceed CREDITS; a credit_in at credit_cnt=CREDITS without a simultaneous valid_out SHALL be dropped (count unchanged).
REQ-020 With credit_cnt=0, grant SHALL be 0 and the FSM SHALL stay LOCKED; a credit_in in that cycle takes effect for grant on the next cycle.
REQ-021 Back-to-back packets SHALL incur one IDLE cycle between tail of one and first flit of the next.

Reset
REQ-022 On rst=1 at a clock edge: FSM=IDLE, ptr=0, owner=0, credit_cnt=CREDITS, xbar_sel=0; grant and valid_out are thus 0 the following cycle.
REQ-023 rst mid-packet SHALL abandon the lock and restore credits to CREDITS with no further grant to the previous owner.

Configuration
REQ-024 Macro PKT_ARB_CREDIT_ERR_EN: when defined, SHALL add output credit_err (1 bit), set sticky on a dropped credit (REQ-019) and cleared only by rst.
REQ-025 Without PKT_ARB_CREDIT_ERR_EN, port credit_err SHALL not exist and dropped credits SHALL be silently ignored.

Verification
REQ-026 Reset, then req=5'b00001, tail=5'b00001 -> LOCKED next cycle, xbar_sel=00001, grant=00001 one cycle, credit_cnt 4->3, ptr=1.
REQ-027 ptr=0, req=5'b11111 held, every flit a tail -> owners served N,E,W,S,L,N in order, one idle cycle between each.
REQ-028 Owner E sends 3-flit packet, req_E drops for 2 cycles mid-packet while req_N=1 -> grant stays 0, N not served until E tail.
REQ-029 CREDITS=4, no credit_in, 6-flit packet -> 4 grants, credit_cnt=0, grant stalls; one credit_in -> exactly one more grant next cycle.
REQ-030 credit_in at credit_cnt=4 -> count stays 4; with PKT_ARB_CREDIT_ERR_EN credit_err=1 until rst.
REQ-031 rst asserted while LOCKED with credit_cnt=1 -> IDLE, credit_cnt=4, xbar_sel=0, ptr=0 next cycle.

Source files
------------

// File: rtl/pkt_credit_arbiter.sv
// -----------------------------------------------------------------------------
// pkt_credit_arbiter
// Five-port (N,E,W,S,L) packet arbiter with wormhole locking and downstream
// credit flow control. An IDLE/LOCKED FSM picks an owner round-robin. The owner
// keeps the crossbar until its tail flit is accepted. Each accepted flit
// consumes one credit.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   req[4:0]   : per-port flit valid (bit0=N, 1=E, 2=W, 3=S, 4=L)
//   tail[4:0]  : per-port tail flag, qualified by req
//   credit_in  : one credit returned by downstream
//   grant[4:0] : one-hot flit accept to the owner (combinational)
//   xbar_sel   : one-hot crossbar select of the current owner (registered)
//   valid_out  : flit forwarded downstream this cycle (|grant)
//   credit_cnt : available downstream credits
//   credit_err : sticky dropped-credit flag (only with PKT_ARB_CREDIT_ERR_EN)
//
// Build option: define PKT_ARB_CREDIT_ERR_EN to add the credit_err output.
// -----------------------------------------------------------------------------
module pkt_credit_arbiter #(
    parameter int unsigned CREDITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic [4:0] tail,
    input  logic       credit_in,
    output logic [4:0] grant,
    output logic [4:0] xbar_sel,
    output logic       valid_out,
    output logic [2:0] credit_cnt
`ifdef PKT_ARB_CREDIT_ERR_EN
    ,
    output logic       credit_err
`endif
);

    localparam int unsigned NPORT = 5;
    localparam int unsigned IDXW  = 3;
    localparam int unsigned CNTW  = 3;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [CNTW-1:0]   credit_q, credit_d;
    logic [NPORT-1:0]  xbar_sel_q, xbar_sel_d;

    logic [NPORT-1:0]  owner_oh_c;
    logic [NPORT-1:0]  grant_c;
    logic              fwd_c;
    logic              drop_c;
    logic [IDXW-1:0]   pick_c;
    logic              pick_vld_c;

    assign owner_oh_c = NPORT'(1) << owner_q;

    // Round-robin pick: first requester at or above ptr, wrapping 4 -> 0.
    always_comb begin
        int unsigned idx;
        pick_c     = '0;
        pick_vld_c = 1'b0;
        idx        = 0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end
            if (!pick_vld_c && req[IDXW'(idx)]) begin
                pick_vld_c = 1'b1;
                pick_c     = IDXW'(idx);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            credit_q   <= CNTW'(CREDITS);
            xbar_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            credit_q   <= credit_d;
            xbar_sel_q <= xbar_sel_d;
        end
    end

    // Next-state: lock on a pick, release once the owner's tail is accepted.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld_c) begin
                    state_d = S_LOCKED;
                    owner_d = pick_c;
                end
            end
            S_LOCKED: begin
                // grant_c only ever carries the owner bit.
                if (|(grant_c & tail)) begin
                    state_d = S_IDLE;
                    ptr_d   = (owner_q == IDXW'(NPORT - 1)) ? '0 : owner_q + IDXW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: grant gated by owner req and credit; next crossbar select.
    always_comb begin
        grant_c    = '0;
        xbar_sel_d = '0;
        if (state_q == S_LOCKED && (|(req & owner_oh_c)) && credit_q != '0) begin
            grant_c = owner_oh_c;
        end
        if (state_d == S_LOCKED) begin
            xbar_sel_d = NPORT'(1) << owner_d;
        end
    end

    assign fwd_c  = |grant_c;
    // A returned credit with the counter already full and no flit leaving.
    assign drop_c = credit_in && !fwd_c && (credit_q == CNTW'(CREDITS));

    // Credit counter: simultaneous consume and return cancel out.
    always_comb begin
        credit_d = credit_q;
        if (fwd_c && !credit_in) begin
            credit_d = credit_q - CNTW'(1);
        end else if (credit_in && !fwd_c && !drop_c) begin
            credit_d = credit_q + CNTW'(1);
        end
    end

`ifdef PKT_ARB_CREDIT_ERR_EN
    logic credit_err_q;

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err_q <= 1'b0;
        end else if (drop_c) begin
            credit_err_q <= 1'b1;
        end
    end

    assign credit_err = credit_err_q;
`endif

    assign grant      = grant_c;
    assign valid_out  = fwd_c;
    assign xbar_sel   = xbar_sel_q;
    assign credit_cnt = credit_q;

endmodule

// File: tb/tb_pkt_credit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pkt_credit_arbiter
// Directed scenarios followed by random traffic. Every cycle the DUT outputs
// are compared with a behavioural model that tracks lock state, owner,
// round-robin pointer and credits as plain integers.
// -----------------------------------------------------------------------------
module tb_pkt_credit_arbiter;

    localparam int unsigned CREDITS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail;
    logic       credit_in;
    logic [4:0] grant;
    logic [4:0] xbar_sel;
    logic       valid_out;
    logic [2:0] credit_cnt;
`ifdef PKT_ARB_CREDIT_ERR_EN
    logic       credit_err;
`endif

    pkt_credit_arbiter #(.CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .tail       (tail),
        .credit_in  (credit_in),
        .grant      (grant),
        .xbar_sel   (xbar_sel),
        .valid_out  (valid_out),
        .credit_cnt (credit_cnt)
`ifdef PKT_ARB_CREDIT_ERR_EN
        ,
        .credit_err (credit_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit m_init;
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_cred;
    bit m_err;

    int n_vec;
    int n_bad;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] onehot(input int i);
        logic [4:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [4:0] model_grant(input logic [4:0] rq);
        if (m_locked && rq[m_owner] && m_cred > 0) return onehot(m_owner);
        return 5'b00000;
    endfunction

    // Apply one cycle of inputs, check outputs, then advance the model.
    task automatic cyc(input logic r, input logic [4:0] rq, input logic [4:0] tl, input logic ci);
        logic [4:0] g;
        bit         found;
        @(negedge clk);
        rst = r; req = rq; tail = tl; credit_in = ci;
        #1;
        g = model_grant(rq);
        if (m_init) begin
            check_eq("grant", 8'(grant), 8'(g));
            check_eq("valid_out", 8'(valid_out), 8'(|g));
            check_eq("xbar_sel", 8'(xbar_sel), m_locked ? 8'(onehot(m_owner)) : 8'h00);
            check_eq("credit_cnt", 8'(credit_cnt), 8'(m_cred));
`ifdef PKT_ARB_CREDIT_ERR_EN
            check_eq("credit_err", 8'(credit_err), 8'(m_err));
`endif
        end
        @(posedge clk);
        if (r) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CREDITS; m_err = 0; m_init = 1;
        end else begin
            if (|g && !ci) m_cred = m_cred - 1;
            else if (ci && !(|g)) begin
                if (m_cred < CREDITS) m_cred = m_cred + 1;
                else m_err = 1;
            end
            if (!m_locked) begin
                found = 0;
                for (int k = 0; k < 5; k++) begin
                    int c;
                    c = (m_ptr + k) % 5;
                    if (!found && rq[c]) begin
                        found = 1; m_owner = c; m_locked = 1;
                    end
                end
            end else if (|g && tl[m_owner]) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % 5;
            end
        end
        #1;
    endtask

    initial begin
        logic [4:0] rq, tl;
        logic       ci, r;
        m_init = 0; n_vec = 0; n_bad = 0;
        rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;

        // Reset.
        cyc(1, 5'b00000, 5'b00000, 0);
        cyc(1, 5'b00000, 5'b00000, 0);
        check_eq("rst_cnt", 8'(credit_cnt), 8'd4);
        check_eq("rst_xbar", 8'(xbar_sel), 8'h00);

        // Single-flit packet from N.
        cyc(0, 5'b00001, 5'b00001, 0);
        check_eq("sf_xbar", 8'(xbar_sel), 8'h01);
        cyc(0, 5'b00001, 5'b00001, 0);
        check_eq("sf_cnt", 8'(credit_cnt), 8'd3);
        check_eq("sf_idle_xbar", 8'(xbar_sel), 8'h00);
        // ptr now 1: E wins over N.
        cyc(0, 5'b00011, 5'b00011, 0);
        check_eq("sf_ptr", 8'(xbar_sel), 8'h02);
        cyc(0, 5'b00011, 5'b00011, 1);

        // Round robin with all requesting, every flit a tail.
        cyc(1, 5'b00000, 5'b00000, 0);
        for (int i = 0; i < 12; i++) cyc(0, 5'b11111, 5'b11111, 1);

        // E packet with req gap while N waits.
        cyc(1, 5'b00000, 5'b00000, 0);
        cyc(0, 5'b00010, 5'b00000, 0);
        cyc(0, 5'b00011, 5'b00000, 0);
        cyc(0, 5'b00001, 5'b00000, 0);
        cyc(0, 5'b00001, 5'b00000, 0);
        check_eq("gap_xbar", 8'(xbar_sel), 8'h02);
        cyc(0, 5'b00011, 5'b00000, 0);
        cyc(0, 5'b00011, 5'b00010, 0);
        cyc(0, 5'b00001, 5'b00001, 0);
        check_eq("gap_next", 8'(xbar_sel), 8'h01);
        cyc(0, 5'b00001, 5'b00001, 0);

        // Credit exhaustion then single credit return.
        cyc(1, 5'b00000, 5'b00000, 0);
        for (int i = 0; i < 7; i++) cyc(0, 5'b00100, 5'b00000, 0);
        check_eq("ex_cnt", 8'(credit_cnt), 8'd0);
        cyc(0, 5'b00100, 5'b00000, 1);
        check_eq("ex_ret", 8'(credit_cnt), 8'd1);
        cyc(0, 5'b00100, 5'b00000, 0);
        check_eq("ex_used", 8'(credit_cnt), 8'd0);
        cyc(0, 5'b00100, 5'b00000, 0);
        cyc(0, 5'b00100, 5'b00100, 1);
        cyc(0, 5'b00100, 5'b00100, 1);

        // Dropped credit at full count.
        cyc(1, 5'b00000, 5'b00000, 0);
        cyc(0, 5'b00000, 5'b00000, 1);
        check_eq("drop_cnt", 8'(credit_cnt), 8'd4);
`ifdef PKT_ARB_CREDIT_ERR_EN
        check_eq("drop_err", 8'(credit_err), 8'd1);
`endif
        cyc(0, 5'b00000, 5'b00000, 0);

        // Reset mid-packet with one credit left.
        cyc(1, 5'b00000, 5'b00000, 0);
        for (int i = 0; i < 4; i++) cyc(0, 5'b01000, 5'b00000, 0);
        check_eq("mid_cnt", 8'(credit_cnt), 8'd1);
        cyc(1, 5'b01000, 5'b00000, 0);
        check_eq("mid_rst_cnt", 8'(credit_cnt), 8'd4);
        check_eq("mid_rst_xbar", 8'(xbar_sel), 8'h00);
        cyc(0, 5'b01001, 5'b00000, 0);
        check_eq("mid_rst_ptr", 8'(xbar_sel), 8'h01);

        // Random traffic.
        for (int n = 0; n < 2500; n++) begin
            rq = 5'($urandom);
            tl = 5'($urandom) & 5'($urandom);
            ci = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 199) == 0);
            cyc(r, rq, tl, ci);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
